// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

endpackage

// File: rtl/loader_byte_packer.sv
// rtl/loader_byte_packer.sv - places incoming bytes into a 32-bit word by byte index
module loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        idx;
  logic [1:0]        slot;
  logic [WORD_W-1:0] shreg;

  // Big-endian fills from the top byte lane downwards.
  assign slot      = BIG_ENDIAN ? (2'd3 - idx) : idx;
  assign word_full = (idx == 2'(BYTES_PER_WORD - 1));
  assign word      = shreg;

  // The index wraps to 0 on the fourth byte, so it is already clear during WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= 2'd0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= 2'd0;
      shreg <= '0;
    end else if (accept) begin
      idx                        <= idx + 2'd1;
      shreg[{slot, 3'b000} +: 8] <= data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing packed words into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t state, next_state;
  logic   accept;
  logic   clear;
  logic   word_full;
  logic   last_q;

  assign accept = in_valid && in_ready;

  loader_byte_packer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .accept   (accept),
    .data     (in_data),
    .word_full(word_full),
    .word     (wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      waddr      <= '0;
      word_count <= '0;
      last_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (clear) begin
        waddr      <= '0;
        word_count <= '0;
        last_q     <= 1'b0;
      end else if (state == WRITE) begin
        waddr      <= waddr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (state == LOAD && accept && word_full) begin
        last_q <= in_last;
      end
    end
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    in_ready   = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE, DONE, ERR: begin
        done     = (state == DONE);
        err      = (state == ERR);
        cpu_hold = (state != DONE);
        if (start) begin
          next_state = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // A full memory rejects the word instead of wrapping onto address 0.
        if (accept) begin
          if (word_full) begin
            next_state = (word_count == CAPACITY) ? ERR : WRITE;
          end else if (in_last) begin
            next_state = ERR;
          end
        end
      end
      WRITE: begin
        we         = 1'b1;
        busy       = 1'b1;
        next_state = last_q ? DONE : LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader on the write side of instruction memory. Accepts a byte stream over a valid/ready handshake, packs every four bytes into one 32-bit MIPS instruction word, and writes the words to sequential imem addresses from 0. While loading, it holds the processor in reset so that fetch and decode only ever see a complete program.

Parameters:
ADDR_W, 6, imem word-address width; capacity 2**ADDR_W words (64 by default).
BIG_ENDIAN, 1, 1: first byte of a word goes to [31:24]; 0: first byte goes to [7:0].

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  begin a new load; sampled only in IDLE, DONE or ERR.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_last  input  1  marks the final byte of the program; qualified by in_valid.
in_ready  output  1  loader accepts a byte this cycle.
we  output  1  imem write enable, single cycle per word.
waddr  output  ADDR_W  imem word address.
wdata  output  32  packed instruction word.
cpu_hold  output  1  processor reset request; high unless state is DONE.
busy  output  1  high in LOAD or WRITE.
done  output  1  level; load finished cleanly.
err  output  1  level; load aborted.
word_count  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, byte index=0, shift register=0, waddr=0, word_count=0.
  - we=0, in_ready=0, busy=0, done=0, err=0, cpu_hold=1.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE/DONE/ERR:
  - in_ready=0.
  - start=1 -> LOAD next edge; clears waddr, word_count, byte index, done and err.
- LOAD:
  - in_ready=1.
  - A byte is accepted when in_valid & in_ready at a rising edge. The byte is placed by BIG_ENDIAN, and the byte index increments.
  - Accepting byte index 3 -> WRITE next cycle; the last flag is latched.
  - in_last accepted with byte index != 3 (partial word) -> ERR. No write occurs.
  - Accepting byte index 3 when word_count == 2**ADDR_W (overflow) -> ERR.
- WRITE (exactly 1 cycle):
  - we=1, in_ready=0, waddr = current address, wdata = packed word.
  - At the end of the cycle: waddr+1, wrapping to 0 only at 2**ADDR_W; word_count+1; byte index=0.
  - Latched last=1 -> DONE, otherwise -> LOAD.
- Latency: the 4th byte accepted at edge N -> we high in the cycle after edge N -> done high after the following edge (last word).
- start while busy is ignored.
- in_valid while in_ready=0 is neither accepted nor lost; the source holds it.
- cpu_hold=0 only in DONE. A new start re-asserts cpu_hold in the same cycle LOAD is entered.
- Reset mid-load aborts immediately. The partial imem contents are not cleaned up.
- Zero-length load (in_last never asserted) stays in LOAD indefinitely; this is the upstream's responsibility.

Decomposition:
- Package imem_loader_pkg:
  - state enum {IDLE, LOAD, WRITE, DONE, ERR};
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- Sub-module loader_byte_packer:
  - shift/placement register, 2-bit byte index, BIG_ENDIAN handling;
  - outputs word_full and the packed word;
  - clear input driven by the FSM.

Test Plan:
- Reset, start, then bytes 20 08 00 05 / 20 09 00 0C with in_last on the final byte, BIG_ENDIAN=1 -> writes waddr 0=0x20080005, waddr 1=0x2009000C; word_count=2; done=1; cpu_hold=0.
- Same stream with in_valid toggled every other cycle -> identical writes; no byte duplicated or dropped; we never high in consecutive cycles.
- BIG_ENDIAN=0, bytes 05 00 08 20 last -> waddr 0=0x20080005.
- in_last on the 3rd byte (AC 08 00 last) -> err=1, done=0, no we, cpu_hold=1. A subsequent start and a valid 4-byte load -> done=1, err=0.
- ADDR_W=2, stream of 5 words -> 4 writes (waddr 0..3), err=1 on the 20th byte, no 5th write.
- Reset asserted after 6 bytes -> all outputs at reset values asynchronously. start pulsed during LOAD -> ignored, load continues unchanged.
